// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write-port arbiter: ALU priority, buffered MDU results
// The ALU wins every cycle it writes a non-zero register; MDU results wait in a small FIFO.
module wb_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_reg,
    input  logic [31:0]              mdu_data,
    output logic                     RegWrite,
    output logic [4:0]               write_reg,
    output logic [31:0]              write_data,
    input  logic [4:0]               query1,
    input  logic [4:0]               query2,
    output logic                     pend1,
    output logic                     pend2,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]       ent_reg_q  [DEPTH];
    logic [4:0]       ent_reg_d  [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic             regwrite_q, regwrite_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             alu_sel;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;

    always_comb begin
        alu_sel   = alu_valid && (alu_reg != 5'd0);
        mdu_ready = (occ_q != OW'(DEPTH));
        // reg-0 results complete the handshake but are never stored
        push      = mdu_valid && mdu_ready && (mdu_reg != 5'd0);
        pop       = !alu_sel && (occ_q != '0);

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        vld_d      = vld_q;
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;

        if (push) begin
            ent_reg_d[wr_ptr_q]  = mdu_reg;
            ent_data_d[wr_ptr_q] = mdu_data;
            vld_d[wr_ptr_q]      = 1'b1;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (alu_sel) begin
            regwrite_d = 1'b1;
            wreg_d     = alu_reg;
            wdata_d    = alu_data;
        end else if (pop) begin
            regwrite_d = 1'b1;
            wreg_d     = ent_reg_q[rd_ptr_q];
            wdata_d    = ent_data_q[rd_ptr_q];
        end
    end

    // A register is pending while its write sits in the buffer or on the output stage.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1[i] = vld_q[i] && (ent_reg_q[i] == query1);
            hit2[i] = vld_q[i] && (ent_reg_q[i] == query2);
        end
        pend1 = (query1 != 5'd0) && ((regwrite_q && (wreg_q == query1)) || (|hit1));
        pend2 = (query2 != 5'd0) && ((regwrite_q && (wreg_q == query2)) || (|hit2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            vld_q      <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            vld_q      <= vld_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            ent_reg_q  <= ent_reg_d;
            ent_data_q <= ent_data_d;
        end
    end

    assign RegWrite   = regwrite_q;
    assign write_reg  = wreg_q;
    assign write_data = wdata_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - directed scoreboard bench for wb_write_arbiter
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mdu_valid, mdu_ready;
    logic [4:0]  alu_reg, mdu_reg, write_reg, query1, query2;
    logic [31:0] alu_data, mdu_data, write_data;
    logic        RegWrite, pend1, pend2;
    logic [2:0]  occupancy;

    wb_write_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .query1(query1), .query2(query2), .pend1(pend1), .pend2(pend2),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got r%0d=0x%0h expected no write (cycle %0d)",
                         write_reg, write_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                chk("wr_reg", {27'd0, write_reg}, {27'd0, e.r});
                chk("wr_data", write_data, e.d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int lat, input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.cyc = cyc + lat;
        e.r   = r;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        alu_valid = v;
        alu_reg   = r;
        alu_data  = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
        mdu_valid = v;
        mdu_reg   = r;
        mdu_data  = d;
    endtask

    task automatic idle_inputs();
        alu(1'b0, 5'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        query1 = 5'd5;
        query2 = 5'd0;
        #3;
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("rst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
        chk("rst_pend1", {31'd0, pend1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // ALU-only write, one-cycle latency, then idle
        alu(1'b1, 5'd5, 32'h1234);
        expect_wr(1, 5'd5, 32'h1234);
        step();
        idle_inputs();
        step();
        chk("alu_idle_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("alu_idle_hold_reg", {27'd0, write_reg}, 32'd5);
        chk("alu_idle_hold_data", write_data, 32'h1234);

        // Contention: r8 waits behind three r3 ALU writes
        query1 = 5'd8;
        query2 = 5'd3;
        alu(1'b1, 5'd3, 32'd1);
        mdu(1'b1, 5'd8, 32'hAAAA);
        expect_wr(1, 5'd3, 32'd1);
        step();
        chk("cont_pend1_c1", {31'd0, pend1}, 32'd1);
        chk("cont_pend2_c1", {31'd0, pend2}, 32'd1);
        mdu(1'b0, 5'd0, 32'd0);
        alu(1'b1, 5'd3, 32'd2);
        expect_wr(1, 5'd3, 32'd2);
        step();
        chk("cont_pend1_c2", {31'd0, pend1}, 32'd1);
        alu(1'b1, 5'd3, 32'd3);
        expect_wr(1, 5'd3, 32'd3);
        step();
        chk("cont_pend1_c3", {31'd0, pend1}, 32'd1);
        alu(1'b0, 5'd0, 32'd0);
        expect_wr(1, 5'd8, 32'hAAAA);
        step();
        chk("cont_pend1_c4", {31'd0, pend1}, 32'd1);
        step();
        chk("cont_pend1_done", {31'd0, pend1}, 32'd0);
        chk("cont_drained", 32'(exp_q.size()), 32'd0);
        query2 = 5'd0;

        // Full buffer: five offers under a busy ALU, four accepted, drain in order
        for (int i = 0; i < 5; i++) begin
            alu(1'b1, 5'd1, 32'(i));
            expect_wr(1, 5'd1, 32'(i));
            mdu(1'b1, 5'(10 + i), 32'h100 + 32'(i));
            if (i == 4) chk("full_ready_5th", {31'd0, mdu_ready}, 32'd0);
            step();
        end
        chk("full_occupancy", {29'd0, occupancy}, 32'd4);
        chk("full_ready", {31'd0, mdu_ready}, 32'd0);
        idle_inputs();
        for (int i = 0; i < 4; i++) expect_wr(1 + i, 5'(10 + i), 32'h100 + 32'(i));
        step();
        chk("full_occ_after_pop", {29'd0, occupancy}, 32'd3);
        chk("full_ready_after_pop", {31'd0, mdu_ready}, 32'd1);
        repeat (4) step();
        chk("full_occ_empty", {29'd0, occupancy}, 32'd0);
        chk("full_drained", 32'(exp_q.size()), 32'd0);

        // Register zero: discarded MDU result, then alu_reg=0 does not block r9
        mdu(1'b1, 5'd0, 32'h55);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        chk("r0_occupancy", {29'd0, occupancy}, 32'd0);
        alu(1'b1, 5'd2, 32'h22);
        expect_wr(1, 5'd2, 32'h22);
        mdu(1'b1, 5'd9, 32'h99);
        step();
        chk("r0_occ_r9", {29'd0, occupancy}, 32'd1);
        mdu(1'b0, 5'd0, 32'd0);
        alu(1'b1, 5'd0, 32'hDEAD);
        expect_wr(1, 5'd9, 32'h99);
        step();
        idle_inputs();
        step();
        chk("r0_occ_after", {29'd0, occupancy}, 32'd0);
        chk("r0_drained", 32'(exp_q.size()), 32'd0);

        // Simultaneous push and pop keeps occupancy steady
        alu(1'b1, 5'd1, 32'd7);
        expect_wr(1, 5'd1, 32'd7);
        mdu(1'b1, 5'd11, 32'hB1);
        step();
        alu(1'b0, 5'd0, 32'd0);
        mdu(1'b1, 5'd12, 32'hB2);
        expect_wr(1, 5'd11, 32'hB1);
        step();
        chk("pushpop_occ", {29'd0, occupancy}, 32'd1);
        mdu(1'b0, 5'd0, 32'd0);
        expect_wr(1, 5'd12, 32'hB2);
        step();
        chk("pushpop_occ_empty", {29'd0, occupancy}, 32'd0);
        step();
        chk("pushpop_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-drain discards buffered entries immediately
        query1 = 5'd21;
        for (int i = 0; i < 3; i++) begin
            alu(1'b1, 5'd4, 32'(i));
            expect_wr(1, 5'd4, 32'(i));
            mdu(1'b1, 5'(20 + i), 32'h200 + 32'(i));
            step();
        end
        idle_inputs();
        expect_wr(1, 5'd20, 32'h200);
        step();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("mid_rst_write_reg", {27'd0, write_reg}, 32'd0);
        chk("mid_rst_write_data", write_data, 32'd0);
        chk("mid_rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("mid_rst_pend1", {31'd0, pend1}, 32'd0);
        chk("mid_rst_ready", {31'd0, mdu_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step();
        chk("post_rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
